aref_instr_arbiter: RTL and testbench
=====================================

AREF_INSTR_ARBITER -- requirements
Module: aref_instr_arbiter

Interface
REQ-001 SHALL have parameter TRP_CYCLES, default 10, WAIT count issued after precharge-all (1..1023).
REQ-002 SHALL have parameter PREA_INSTR, default 32'h4000_0400, DDR precharge-all instruction word.
REQ-003 SHALL have parameter REF_INSTR, default 32'h4000_0000, DDR refresh instruction word.
REQ-004 SHALL have parameter WAIT_OP, default 4'h1, opcode placed in bits [31:28] of generated WAIT words.
REQ-005 SHALL have ports: clk in 1, clock; rst in 1, reset.
REQ-006 SHALL have ports: aref_set_interval in 1, load interval; aref_interval in 28, refresh interval in cycles.
REQ-007 SHALL have ports: aref_set_trfc in 1, load tRFC; aref_trfc in 28, tRFC in cycles.
REQ-008 SHALL have ports: host_en in 1, host instruction valid; host_instr in 32; host_lock in 1, host sequence must not be split; host_ack out 1.
REQ-009 SHALL have ports: disp_en out 1; disp_instr out 32; disp_ack in 1, dispatcher accepted.
REQ-010 SHALL have ports: aref_busy out 1, refresh sequence owns dispatcher; aref_pending out 1; aref_overrun out 1, sticky missed-interval flag; aref_count out 16, refreshes issued.
REQ-011 SHALL use reset rst, synchronous, active-high; clock clk.

Function
REQ-012 SHALL transfer a word only in a cycle with disp_en=1 and disp_ack=1; disp_instr stable while disp_en=1 and not acked.
REQ-013 SHALL hold interval and tRFC registers; aref_set_interval loads interval register and down-counter with aref_interval in the same cycle.
REQ-014 SHALL treat interval register 0 as refresh disabled: counter holds 0, no pending ever raised.
REQ-015 SHALL decrement the counter each cycle when enabled; on counter==1, reload interval and set pending; if pending already set, also set aref_overrun (sticky until rst).
REQ-016 SHALL have FSM states IDLE, PEND, PREA, WRP, REF, WRFC.
REQ-017 IDLE/PEND: disp_en=host_en, disp_instr=host_instr, host_ack=disp_ack (combinational pass-through), aref_busy=0.
REQ-018 IDLE -> PEND when pending set; PEND -> PREA next cycle when host_lock=0, else stay; host transfer in that PEND cycle still completes.
REQ-019 PREA..WRFC: host_ack=0, aref_busy=1, disp_en=1, FSM word driven; advance only on disp_ack.
REQ-020 PREA drives PREA_INSTR; WRP drives {WAIT_OP,18'b0,TRP_CYCLES[9:0]}; REF drives REF_INSTR.
REQ-021 On REF ack: clear pending, increment aref_count (wraps 16'hFFFF->0), latch remaining=tRFC register; go WRFC, or IDLE if tRFC==0.
REQ-022 WRFC drives WAIT with count=min(remaining,1023); on ack remaining-=count; IDLE when remaining reaches 0.
REQ-023 aref_set_trfc during a sequence SHALL NOT alter the latched remaining value.
REQ-024 Interval expiry during a sequence SHALL set pending for the next sequence (overrun rule of REQ-015 applies).
REQ-025 Simultaneous aref_set_interval and expiry: the load wins, no pending raised that cycle.

Reset
REQ-026 On rst: FSM IDLE; interval, tRFC, counter, remaining=0; pending, aref_overrun, aref_busy=0; aref_count=0; disp_en follows host pass-through.
REQ-027 rst mid-sequence SHALL abandon the sequence; no further FSM words after the reset cycle.

Verification
REQ-028 interval=100, trfc=0, host idle, disp_ack=1 -> PREA, WAIT(10), REF issued starting cycle ~101; aref_count=1; repeat every 100 cycles.
REQ-029 trfc=2500 -> after REF, WAITs of 1023, 1023, 454 then IDLE.
REQ-030 host_lock=1 held 50 cycles at expiry -> host words keep passing, aref_pending=1, PREA issued the cycle after host_lock falls.
REQ-031 disp_ack=0 for 20 cycles during PREA -> PREA_INSTR held stable, host_ack=0, no advance.
REQ-032 interval=10, disp_ack held 0 -> second expiry sets aref_overrun=1, stays 1 until rst.
REQ-033 rst asserted in WRFC -> next cycle IDLE, aref_busy=0, aref_count=0, host pass-through restored.

Source files
------------

// File: rtl/aref_instr_arbiter.sv
// Auto-refresh arbiter. On each refresh interval it takes the DDR instruction dispatcher
// from the host and issues precharge-all, a tRP wait, a refresh, then tRFC waits.
module aref_instr_arbiter #(
  parameter int unsigned TRP_CYCLES = 10,
  parameter logic [31:0] PREA_INSTR = 32'h4000_0400,
  parameter logic [31:0] REF_INSTR  = 32'h4000_0000,
  parameter logic [3:0]  WAIT_OP    = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        aref_set_interval,
  input  logic [27:0] aref_interval,
  input  logic        aref_set_trfc,
  input  logic [27:0] aref_trfc,
  input  logic        host_en,
  input  logic [31:0] host_instr,
  input  logic        host_lock,
  output logic        host_ack,
  output logic        disp_en,
  output logic [31:0] disp_instr,
  input  logic        disp_ack,
  output logic        aref_busy,
  output logic        aref_pending,
  output logic        aref_overrun,
  output logic [15:0] aref_count,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PEND = 3'd1,
    ST_PREA = 3'd2,
    ST_WRP  = 3'd3,
    ST_REF  = 3'd4,
    ST_WRFC = 3'd5
  } state_t;

  localparam logic [9:0]  TRP_CNT  = 10'(TRP_CYCLES);
  localparam logic [27:0] WAIT_MAX = 28'd1023;

  function automatic logic [9:0] wait_clip(input logic [27:0] v);
    return (v > WAIT_MAX) ? 10'd1023 : v[9:0];
  endfunction

  function automatic logic [31:0] wait_word(input logic [9:0] n);
    return {WAIT_OP, 18'b0, n};
  endfunction

  logic [27:0] interval_q, interval_d;
  logic [27:0] trfc_q, trfc_d;
  logic [27:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic [27:0] remaining_q;
  logic [15:0] count_q;
  logic [31:0] word_q;
  logic        busy_q;
  state_t      state_q;

  logic        expire;
  logic        ref_done;
  logic [9:0]  wrfc_step;
  logic [27:0] rem_after;

  // A load on the same cycle as an expiry restarts the interval, so no pending is raised.
  assign expire    = (interval_q != '0) && (cnt_q == 28'd1) && !aref_set_interval;
  assign ref_done  = (state_q == ST_REF) && disp_ack;
  assign wrfc_step = wait_clip(remaining_q);
  assign rem_after = remaining_q - {18'b0, wrfc_step};

  always_comb begin
    interval_d = interval_q;
    trfc_d     = trfc_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;

    if (aref_set_interval) begin
      interval_d = aref_interval;
      cnt_d      = aref_interval;
    end else if (interval_q == '0) begin
      cnt_d = '0;
    end else if (cnt_q == 28'd1) begin
      cnt_d = interval_q;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 28'd1;
    end

    if (aref_set_trfc) trfc_d = aref_trfc;

    // Overrun means an expiry found a refresh still owed that is not being retired now.
    if (ref_done) pending_d = 1'b0;
    if (expire) begin
      if (pending_q && !ref_done) overrun_d = 1'b1;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      interval_q <= '0;
      trfc_q     <= '0;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      interval_q <= interval_d;
      trfc_q     <= trfc_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
    end
  end

  // word_q always holds the word of the state being entered, so disp_instr is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      word_q      <= '0;
      count_q     <= '0;
      remaining_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pending_q) state_q <= ST_PEND;
        end
        ST_PEND: begin
          if (!host_lock) begin
            state_q <= ST_PREA;
            busy_q  <= 1'b1;
            word_q  <= PREA_INSTR;
          end
        end
        ST_PREA: begin
          if (disp_ack) begin
            state_q <= ST_WRP;
            word_q  <= wait_word(TRP_CNT);
          end
        end
        ST_WRP: begin
          if (disp_ack) begin
            state_q <= ST_REF;
            word_q  <= REF_INSTR;
          end
        end
        ST_REF: begin
          if (disp_ack) begin
            count_q     <= count_q + 16'd1;
            remaining_q <= trfc_q;
            if (trfc_q == '0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_WRFC;
              word_q  <= wait_word(wait_clip(trfc_q));
            end
          end
        end
        ST_WRFC: begin
          if (disp_ack) begin
            remaining_q <= rem_after;
            if (rem_after == '0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              word_q <= wait_word(wait_clip(rem_after));
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Handshake: a word moves only when disp_en && disp_ack; disp_en never drops before ack.
  assign disp_en      = busy_q ? 1'b1   : host_en;
  assign disp_instr   = busy_q ? word_q : host_instr;
  assign host_ack     = busy_q ? 1'b0   : disp_ack;
  assign aref_busy    = busy_q;
  assign aref_pending = pending_q;
  assign aref_overrun = overrun_q;
  assign aref_count   = count_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_aref_instr_arbiter.sv
// Bench for aref_instr_arbiter: directed scenarios plus random traffic, checked against
// an interval/pending model and expected-word queues for refresh and host words.
`timescale 1ns/1ps
module tb_aref_instr_arbiter;

  localparam int          TRP    = 10;
  localparam logic [31:0] PREA_W = 32'h4000_0400;
  localparam logic [31:0] REF_W  = 32'h4000_0000;
  localparam logic [3:0]  WOP    = 4'h1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aref_set_interval = 1'b0;
  logic [27:0] aref_interval = '0;
  logic        aref_set_trfc = 1'b0;
  logic [27:0] aref_trfc = '0;
  logic        host_en = 1'b0;
  logic [31:0] host_instr = '0;
  logic        host_lock = 1'b0;
  logic        host_ack;
  logic        disp_en;
  logic [31:0] disp_instr;
  logic        disp_ack = 1'b1;
  logic        aref_busy;
  logic        aref_pending;
  logic        aref_overrun;
  logic [15:0] aref_count;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  aref_instr_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .aref_set_interval (aref_set_interval),
    .aref_interval     (aref_interval),
    .aref_set_trfc     (aref_set_trfc),
    .aref_trfc         (aref_trfc),
    .host_en           (host_en),
    .host_instr        (host_instr),
    .host_lock         (host_lock),
    .host_ack          (host_ack),
    .disp_en           (disp_en),
    .disp_instr        (disp_instr),
    .disp_ack          (disp_ack),
    .aref_busy         (aref_busy),
    .aref_pending      (aref_pending),
    .aref_overrun      (aref_overrun),
    .aref_count        (aref_count),
    .dbg_state_o       (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] host_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wait_w(input int n);
    logic [9:0] n10;
    n10 = 10'(n);
    return {WOP, 18'b0, n10};
  endfunction

  // ---------------- reference model + monitor ----------------
  int          cyc = 0;
  int          m_load = 0;
  int          m_iv = 0;
  int          m_trfc = 0;
  bit          m_pending = 0;
  bit          m_overrun = 0;
  logic [15:0] m_count = '0;
  bit          hold_v = 0;
  logic [31:0] hold_w = '0;
  int          host_taken = 0;

  always @(negedge clk) begin
    bit ref_evt;
    logic [31:0] w;
    int r, c;
    cyc++;
    ref_evt = 0;
    if (rst) begin
      m_iv = 0; m_trfc = 0; m_pending = 0; m_overrun = 0; m_count = '0;
      exp_q.delete();
      hold_v = 0;
    end else begin
      chk("pending", 32'(aref_pending), 32'(m_pending));
      chk("overrun", 32'(aref_overrun), 32'(m_overrun));
      chk("count", 32'(aref_count), 32'(m_count));
      if (hold_v && aref_busy) chk("hold_stable", disp_instr, hold_w);
      if (aref_busy) begin
        chk("busy_host_ack", 32'(host_ack), 32'd0);
        chk("busy_disp_en", 32'(disp_en), 32'd1);
      end else begin
        chk("pass_en", 32'(disp_en), 32'(host_en));
        chk("pass_ack", 32'(host_ack), 32'(disp_ack));
      end
      if (disp_en && disp_ack) begin
        if (host_ack) begin
          if (host_q.size() == 0) chk("host_unexpected", disp_instr, 32'hxxxx_xxxx);
          else begin
            w = host_q.pop_front();
            chk("host_word", disp_instr, w);
          end
          host_taken++;
        end else begin
          if (exp_q.size() == 0) chk("fsm_unexpected", disp_instr, 32'hxxxx_xxxx);
          else begin
            w = exp_q.pop_front();
            chk("fsm_word", disp_instr, w);
            if (w == REF_W) ref_evt = 1;
          end
        end
      end
      hold_v = aref_busy && disp_en && !disp_ack;
      hold_w = disp_instr;

      if (ref_evt) begin
        m_pending = 0;
        m_count++;
        r = m_trfc;
        while (r > 0) begin
          c = (r > 1023) ? 1023 : r;
          exp_q.push_back(wait_w(c));
          r -= c;
        end
      end
      if (aref_set_trfc) m_trfc = int'(aref_trfc);
      if (aref_set_interval) begin
        m_iv = int'(aref_interval);
        m_load = cyc;
      end else if (m_iv != 0 && cyc > m_load && ((cyc - m_load) % m_iv) == 0) begin
        if (m_pending) m_overrun = 1;
        else begin
          exp_q.push_back(PREA_W);
          exp_q.push_back(wait_w(TRP));
          exp_q.push_back(REF_W);
        end
        m_pending = 1;
      end
    end
  end

  // ---------------- drivers ----------------
  bit host_run = 0;
  int ack_mode = 0;
  int host_seen = 0;

  initial begin
    forever begin
      @(posedge clk); #2;
      if (host_taken != host_seen) begin
        host_seen = host_taken;
        host_en = 1'b0;
      end
      if (!host_run) begin
        host_en = 1'b0;
        host_q.delete();
      end else if (!host_en && $urandom_range(0, 2) != 0) begin
        host_instr = {4'hC, 28'($urandom)};
        host_q.push_back(host_instr);
        host_en = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      case (ack_mode)
        0: disp_ack = 1'b1;
        1: disp_ack = 1'b0;
        default: disp_ack = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  task automatic set_iv(input int v);
    aref_set_interval = 1'b1;
    aref_interval = 28'(v);
    @(posedge clk); #1;
    aref_set_interval = 1'b0;
  endtask

  task automatic set_trfc(input int v);
    aref_set_trfc = 1'b1;
    aref_trfc = 28'(v);
    @(posedge clk); #1;
    aref_set_trfc = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int rise1, rise2, n, found, c0, taken0;
    bit prev_busy;
    logic [31:0] w;

    repeat (4) @(posedge clk);
    #1;
    chk("rst_busy", 32'(aref_busy), 32'd0);
    chk("rst_pending", 32'(aref_pending), 32'd0);
    chk("rst_overrun", 32'(aref_overrun), 32'd0);
    chk("rst_count", 32'(aref_count), 32'd0);
    chk("rst_disp_en", 32'(disp_en), 32'(host_en));
    rst = 1'b0;
    @(posedge clk); #1;

    // Periodic refresh with tRFC 0: busy appears 2 cycles after each expiry.
    set_iv(100);
    rise1 = -1; rise2 = -1; prev_busy = 0;
    for (int i = 1; i <= 250; i++) begin
      @(posedge clk); #1;
      if (aref_busy && !prev_busy) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      prev_busy = aref_busy;
      if (i == 150) chk("count_after_first", 32'(aref_count), 32'd1);
    end
    chk("first_seq_start", 32'(rise1), 32'd102);
    chk("second_seq_start", 32'(rise2), 32'd102 + 32'd100);
    chk("count_after_second", 32'(aref_count), 32'd2);

    // tRFC 2500 splits into 1023, 1023, 454 (checked word-by-word by the monitor).
    set_trfc(2500);
    repeat (120) begin @(posedge clk); #1; end
    chk("count_after_trfc_seq", 32'(aref_count), 32'd3);
    chk("idle_after_trfc_seq", 32'(aref_busy), 32'd0);

    // Dispatcher stalls in PREA.
    ack_mode = 1;
    found = 0;
    for (int i = 0; i < 150 && !found; i++) begin
      @(posedge clk); #1;
      if (aref_busy) found = 1;
    end
    chk("prea_reached", 32'(found), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("stall_prea_word", disp_instr, PREA_W);
      chk("stall_host_ack", 32'(host_ack), 32'd0);
    end
    ack_mode = 0;
    repeat (10) begin @(posedge clk); #1; end

    // host_lock holds off the sequence while host words keep flowing.
    host_run = 1;
    host_lock = 1'b1;
    set_iv(60);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (aref_pending) found = 1;
    end
    chk("lock_pending_seen", 32'(found), 32'd1);
    taken0 = host_taken;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      chk("lock_not_busy", 32'(aref_busy), 32'd0);
    end
    chk("lock_host_flowed", 32'(host_taken > taken0), 32'd1);
    host_lock = 1'b0;
    @(posedge clk); #1;
    chk("unlock_busy", 32'(aref_busy), 32'd1);
    chk("unlock_prea", disp_instr, PREA_W);
    host_run = 0;

    // Missed interval sets the sticky overrun flag.
    ack_mode = 1;
    set_iv(10);
    repeat (25) begin @(posedge clk); #1; end
    chk("overrun_set", 32'(aref_overrun), 32'd1);
    ack_mode = 0;
    repeat (30) begin @(posedge clk); #1; end
    chk("overrun_sticky", 32'(aref_overrun), 32'd1);

    // Reloading tRFC mid-sequence must not change the waits already owed.
    set_iv(200);
    c0 = int'(aref_count);
    found = 0;
    for (int i = 0; i < 450 && !found; i++) begin
      @(posedge clk); #1;
      if (int'(aref_count) != c0) found = 1;
    end
    chk("trfc_seq_ref", 32'(found), 32'd1);
    set_trfc(5);
    repeat (20) begin @(posedge clk); #1; end

    // Random traffic.
    host_run = 1;
    ack_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if (host_lock) host_lock = ($urandom_range(0, 7) != 0);
      else           host_lock = ($urandom_range(0, 19) == 0);
      aref_set_interval = ($urandom_range(0, 199) == 0);
      aref_interval = ($urandom_range(0, 5) == 0) ? 28'd0 : 28'($urandom_range(3, 80));
      aref_set_trfc = ($urandom_range(0, 149) == 0);
      aref_trfc = 28'($urandom_range(0, 2200));
      @(posedge clk); #1;
    end
    aref_set_interval = 1'b0;
    aref_set_trfc = 1'b0;
    host_lock = 1'b0;
    host_run = 0;
    ack_mode = 0;
    repeat (3) begin @(posedge clk); #1; end

    // Reset in the middle of the tRFC waits.
    set_trfc(3000);
    set_iv(20);
    c0 = int'(aref_count);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (int'(aref_count) != c0) found = 1;
    end
    chk("rst_test_in_wrfc", 32'(found), 32'd1);
    w = disp_instr;
    chk("rst_test_wait_op", {28'b0, w[31:28]}, {28'b0, WOP});
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(aref_busy), 32'd0);
    chk("midrst_count", 32'(aref_count), 32'd0);
    chk("midrst_pending", 32'(aref_pending), 32'd0);
    chk("midrst_disp_en", 32'(disp_en), 32'(host_en));
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("postrst_idle", 32'(aref_busy), 32'd0);
    end
    taken0 = host_taken;
    host_run = 1;
    repeat (40) begin @(posedge clk); #1; end
    host_run = 0;
    repeat (5) begin @(posedge clk); #1; end
    chk("postrst_host_flow", 32'(host_taken > taken0), 32'd1);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
